// File: rtl/window_buffer_v3_pkg.sv
// Shared types and elaboration helpers for the window buffer.
// coord_t is wide enough for slot pointers and stride phases at any supported geometry.
package window_buffer_pkg;

   typedef logic [15:0] coord_t;

   function automatic int n_windows(input int w, input int h, input int k, input int s);
      return ((w - k) / s + 1) * ((h - k) / s + 1);
   endfunction

   function automatic bit is_stride_aligned(input int w, input int h, input int k, input int s);
      return (s > 0) && (((w - k) % s) == 0) && (((h - k) % s) == 0);
   endfunction

endpackage

// File: rtl/window_buffer_v3_if.sv
// Pixel-in / window-out handshake bundle; WINDOW_BUFFER_COORD_EN adds window top-left coordinates.
// slave = window buffer side, master = pixel source plus window consumer.
interface window_buffer_v3_if #(
   parameter int K_KERNEL = 3,
   parameter int BWD      = 8,
   parameter int N_CH     = 1
`ifdef WINDOW_BUFFER_COORD_EN
   ,
   parameter int CW       = 3,
   parameter int RW       = 3
`endif
);
   logic [N_CH-1:0][BWD-1:0]                             i_data;
   logic                                                 i_data_valid;
   logic                                                 i_data_ready;
   logic [K_KERNEL-1:0][K_KERNEL-1:0][N_CH-1:0][BWD-1:0] o_window;
   logic                                                 o_window_valid;
   logic                                                 o_window_ready;
   logic                                                 o_window_end;
`ifdef WINDOW_BUFFER_COORD_EN
   logic [CW-1:0]                                        o_win_col;
   logic [RW-1:0]                                        o_win_row;

   modport slave (
      input  i_data, i_data_valid, o_window_ready,
      output i_data_ready, o_window, o_window_valid, o_window_end, o_win_col, o_win_row
   );
   modport master (
      output i_data, i_data_valid, o_window_ready,
      input  i_data_ready, o_window, o_window_valid, o_window_end, o_win_col, o_win_row
   );
`else
   modport slave (
      input  i_data, i_data_valid, o_window_ready,
      output i_data_ready, o_window, o_window_valid, o_window_end
   );
   modport master (
      output i_data, i_data_valid, o_window_ready,
      input  i_data_ready, o_window, o_window_valid, o_window_end
   );
`endif
endinterface

// File: rtl/window_buffer_v3_line_ram.sv
// One image row of pixel storage: synchronous write, asynchronous read (old data on same-address write).
// No latency on read; no flow control, the owner gates i_we.
module window_line_ram #(
   parameter int DEPTH = 8,
   parameter int N_CH  = 1,
   parameter int BWD   = 8
) (
   input  logic                       clk,
   input  logic                       i_we,
   input  logic [$clog2(DEPTH)-1:0]   i_waddr,
   input  logic [N_CH-1:0][BWD-1:0]   i_wdata,
   input  logic [$clog2(DEPTH)-1:0]   i_raddr,
   output logic [N_CH-1:0][BWD-1:0]   o_rdata
);
   logic [N_CH-1:0][BWD-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/window_buffer_v3.sv
// Raster pixels in, K x K x N_CH strided windows out (WINDOW_BUFFER_COORD_EN adds top-left coords); window valid 1 cycle
// after its completing pixel; i_data_ready = !o_window_valid || o_window_ready, so no pixel enters while a window stalls.
module window_buffer_v3
   import window_buffer_pkg::*;
#(
   parameter int IMG_W    = 8,
   parameter int IMG_H    = 8,
   parameter int K_KERNEL = 3,
   parameter int BWD      = 8,
   parameter int N_CH     = 1,
   parameter int STRIDE   = 1
) (
   input  logic              clk,
   input  logic              clear_n,
   window_buffer_v3_if.slave io_bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] C_LAST    = CW'(IMG_W - 1);
   localparam logic [CW-1:0] C_K       = CW'(K_KERNEL - 1);
   localparam logic [RW-1:0] R_LAST    = RW'(IMG_H - 1);
   localparam logic [RW-1:0] R_K       = RW'(K_KERNEL - 1);
   localparam coord_t        SLOT_LAST = coord_t'(K_KERNEL - 2);
   localparam coord_t        S_LAST    = coord_t'(STRIDE - 1);

   typedef logic [N_CH-1:0][BWD-1:0] pix_t;

   if (!is_stride_aligned(IMG_W, IMG_H, K_KERNEL, STRIDE)) begin : g_bad_stride
      $fatal(1, "window_buffer_v3: (IMG_W-K_KERNEL) and (IMG_H-K_KERNEL) must be multiples of STRIDE");
   end

   logic [CW-1:0] r_col, w_col_nxt;
   logic [RW-1:0] r_row, w_row_nxt;
   coord_t        r_slot, w_slot_nxt, r_sc, w_sc_nxt, r_rc, w_rc_nxt;
   logic          w_rdy, w_acc, w_win, w_last;
   logic          r_vld, r_end;
   logic [K_KERNEL-1:0][K_KERNEL-1:0][N_CH-1:0][BWD-1:0] r_win;
   logic [K_KERNEL-1:0][N_CH-1:0][BWD-1:0]               w_newcol;
   pix_t          w_rd [K_KERNEL-1];

   assign w_rdy  = !r_vld || io_bus.o_window_ready;
   assign w_acc  = io_bus.i_data_valid && w_rdy;
   assign w_win  = (r_row >= R_K) && (r_col >= C_K) && (r_sc == '0) && (r_rc == '0);
   assign w_last = (r_col == C_LAST) && (r_row == R_LAST);

   for (genvar gi = 0; gi < K_KERNEL - 1; gi++) begin : g_line
      window_line_ram #(.DEPTH(IMG_W), .N_CH(N_CH), .BWD(BWD)) u_ram (
         .clk     (clk),
         .i_we    (w_acc && (r_slot == coord_t'(gi))),
         .i_waddr (r_col),
         .i_wdata (io_bus.i_data),
         .i_raddr (r_col),
         .o_rdata (w_rd[gi])
      );
   end

   // Right column, oldest row first: element j lives in slot (r_slot + j) mod (K-1).
   always_comb begin
      w_newcol = '0;
      for (int j = 0; j < K_KERNEL - 1; j++) begin
         for (int s = 0; s < K_KERNEL - 1; s++) begin
            if (r_slot == coord_t'((s - j + K_KERNEL - 1) % (K_KERNEL - 1))) w_newcol[j] = w_rd[s];
         end
      end
      w_newcol[K_KERNEL-1] = io_bus.i_data;
   end

   always_comb begin
      w_col_nxt  = r_col + CW'(1);
      w_row_nxt  = r_row;
      w_slot_nxt = r_slot;
      w_rc_nxt   = r_rc;
      if (r_col == C_LAST) begin
         w_col_nxt = '0;
         if (r_row == R_LAST) begin
            w_row_nxt  = '0;
            w_slot_nxt = '0;
         end else begin
            w_row_nxt  = r_row + RW'(1);
            w_slot_nxt = (r_slot == SLOT_LAST) ? '0 : r_slot + coord_t'(1);
         end
         w_rc_nxt = ((w_row_nxt == R_K) || (r_rc == S_LAST)) ? '0 : r_rc + coord_t'(1);
      end
      w_sc_nxt = ((w_col_nxt == C_K) || (r_sc == S_LAST)) ? '0 : r_sc + coord_t'(1);
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_col  <= '0;
         r_row  <= '0;
         r_slot <= '0;
         r_sc   <= '0;
         r_rc   <= '0;
      end else if (w_acc) begin
         r_col  <= w_col_nxt;
         r_row  <= w_row_nxt;
         r_slot <= w_slot_nxt;
         r_sc   <= w_sc_nxt;
         r_rc   <= w_rc_nxt;
      end
   end

`ifdef WINDOW_BUFFER_COORD_EN
   logic [CW-1:0] r_wcol;
   logic [RW-1:0] r_wrow;
`endif

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_vld  <= 1'b0;
         r_end  <= 1'b0;
`ifdef WINDOW_BUFFER_COORD_EN
         r_wcol <= '0;
         r_wrow <= '0;
`endif
      end else if (w_acc && w_win) begin
         r_vld  <= 1'b1;
         r_end  <= w_last;
`ifdef WINDOW_BUFFER_COORD_EN
         r_wcol <= r_col - C_K;
         r_wrow <= r_row - R_K;
`endif
      end else if (io_bus.o_window_ready) begin
         r_vld  <= 1'b0;
         r_end  <= 1'b0;
      end
   end

   // Window register shifts on every accepted pixel; acceptance is blocked while a window stalls.
   always_ff @(posedge clk) begin
      if (w_acc) begin
         for (int r = 0; r < K_KERNEL; r++) begin
            for (int c = 0; c < K_KERNEL - 1; c++) r_win[r][c] <= r_win[r][c+1];
            r_win[r][K_KERNEL-1] <= w_newcol[r];
         end
      end
   end

   assign io_bus.i_data_ready   = w_rdy;
   assign io_bus.o_window       = r_win;
   assign io_bus.o_window_valid = r_vld;
   assign io_bus.o_window_end   = r_end;
`ifdef WINDOW_BUFFER_COORD_EN
   assign io_bus.o_win_col      = r_wcol;
   assign io_bus.o_win_row      = r_wrow;
`endif
endmodule

// File: tb/tb_window_buffer_v3.sv
// Bench for window_buffer_v3: three geometries (8x8, 10x6x3ch, 7x7 stride 2) against a window-enumeration model.
// Coordinates are compared only when WINDOW_BUFFER_COORD_EN is defined.
module tb_window_buffer_v3;
   localparam int K = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         clear_n;
   int           sel;
   logic         src_vld, snk_rdy;
   logic [23:0]  src_dat;
   logic         w_rdy, w_vld, w_end;
   logic [215:0] w_win;
   logic [7:0]   w_cx, w_cy;

   int vectors = 0;
   int errors  = 0;
   int cfg_w, cfg_h, cfg_n, cfg_s;

   logic [23:0]  pixq[$];
   logic [215:0] exp_win[$], obs_win[$];
   bit           exp_end[$], obs_end[$];
   int           exp_x[$], exp_y[$], obs_x[$], obs_y[$], obs_cyc[$], acc_cyc[$];

   window_buffer_v3_if #(.K_KERNEL(3), .BWD(8), .N_CH(1)
`ifdef WINDOW_BUFFER_COORD_EN
      , .CW(3), .RW(3)
`endif
   ) if_a ();
   window_buffer_v3_if #(.K_KERNEL(3), .BWD(8), .N_CH(3)
`ifdef WINDOW_BUFFER_COORD_EN
      , .CW(4), .RW(3)
`endif
   ) if_b ();
   window_buffer_v3_if #(.K_KERNEL(3), .BWD(8), .N_CH(1)
`ifdef WINDOW_BUFFER_COORD_EN
      , .CW(3), .RW(3)
`endif
   ) if_c ();

   window_buffer_v3 #(.IMG_W(8), .IMG_H(8), .K_KERNEL(3), .BWD(8), .N_CH(1), .STRIDE(1))
      dut_a (.clk(clk), .clear_n(clear_n), .io_bus(if_a.slave));
   window_buffer_v3 #(.IMG_W(10), .IMG_H(6), .K_KERNEL(3), .BWD(8), .N_CH(3), .STRIDE(1))
      dut_b (.clk(clk), .clear_n(clear_n), .io_bus(if_b.slave));
   window_buffer_v3 #(.IMG_W(7), .IMG_H(7), .K_KERNEL(3), .BWD(8), .N_CH(1), .STRIDE(2))
      dut_c (.clk(clk), .clear_n(clear_n), .io_bus(if_c.slave));

   assign if_a.i_data = src_dat[7:0];
   assign if_b.i_data = src_dat;
   assign if_c.i_data = src_dat[7:0];
   assign if_a.i_data_valid = src_vld && (sel == 0);
   assign if_b.i_data_valid = src_vld && (sel == 1);
   assign if_c.i_data_valid = src_vld && (sel == 2);
   assign if_a.o_window_ready = snk_rdy;
   assign if_b.o_window_ready = snk_rdy;
   assign if_c.o_window_ready = snk_rdy;

   always_comb begin
      w_rdy = 1'b0; w_vld = 1'b0; w_end = 1'b0; w_win = '0; w_cx = '0; w_cy = '0;
      case (sel)
         0: begin
            w_rdy = if_a.i_data_ready; w_vld = if_a.o_window_valid; w_end = if_a.o_window_end;
            w_win = 216'(if_a.o_window);
`ifdef WINDOW_BUFFER_COORD_EN
            w_cx = 8'(if_a.o_win_col); w_cy = 8'(if_a.o_win_row);
`endif
         end
         1: begin
            w_rdy = if_b.i_data_ready; w_vld = if_b.o_window_valid; w_end = if_b.o_window_end;
            w_win = 216'(if_b.o_window);
`ifdef WINDOW_BUFFER_COORD_EN
            w_cx = 8'(if_b.o_win_col); w_cy = 8'(if_b.o_win_row);
`endif
         end
         default: begin
            w_rdy = if_c.i_data_ready; w_vld = if_c.o_window_valid; w_end = if_c.o_window_end;
            w_win = 216'(if_c.o_window);
`ifdef WINDOW_BUFFER_COORD_EN
            w_cx = 8'(if_c.o_win_col); w_cy = 8'(if_c.o_win_row);
`endif
         end
      endcase
   end

   task automatic set_cfg(input int s, input int w, input int h, input int n, input int st);
      sel = s; cfg_w = w; cfg_h = h; cfg_n = n; cfg_s = st;
      pixq.delete();
   endtask

   // mode 0: value = base + raster index + 64*channel; mode 1: random samples
   task automatic gen_frame(input int mode, input int base);
      for (int y = 0; y < cfg_h; y++) begin
         for (int x = 0; x < cfg_w; x++) begin
            logic [23:0] p;
            p = '0;
            for (int ch = 0; ch < cfg_n; ch++)
               p[ch*8 +: 8] = (mode == 0) ? 8'(base + y*cfg_w + x + 64*ch) : 8'($urandom_range(0, 255));
            pixq.push_back(p);
         end
      end
   endtask

   // Enumerate every stride-aligned K x K window of each frame in completion (raster) order.
   task automatic build_exp(input int nfr);
      exp_win.delete(); exp_end.delete(); exp_x.delete(); exp_y.delete();
      for (int f = 0; f < nfr; f++) begin
         for (int y = 0; y + K <= cfg_h; y += cfg_s) begin
            for (int x = 0; x + K <= cfg_w; x += cfg_s) begin
               logic [215:0] wv;
               logic [23:0]  p;
               wv = '0;
               for (int r = 0; r < K; r++)
                  for (int c = 0; c < K; c++) begin
                     p = pixq[f*cfg_w*cfg_h + (y + r)*cfg_w + x + c];
                     for (int ch = 0; ch < cfg_n; ch++) wv[((r*K + c)*cfg_n + ch)*8 +: 8] = p[ch*8 +: 8];
                  end
               exp_win.push_back(wv);
               exp_end.push_back((y == cfg_h - K) && (x == cfg_w - K));
               exp_x.push_back(x);
               exp_y.push_back(y);
            end
         end
      end
   endtask

   task automatic clear_obs();
      obs_win.delete(); obs_end.delete(); obs_x.delete(); obs_y.delete(); obs_cyc.delete(); acc_cyc.delete();
   endtask

   task automatic drive(input int npix, input bit rnd, input int drain_n);
      int pi = 0, cyc = 0, drain = 0;
      bit prev_stall = 1'b0, prev_end = 1'b0;
      logic [215:0] prev_win = '0;
      while (pi < npix || drain < drain_n) begin
         @(posedge clk); #1;
         src_vld = (pi < npix) && (!rnd || ($urandom_range(0, 1) == 1));
         src_dat = '0;
         if (pi < npix) src_dat = pixq[pi];
         snk_rdy = !rnd || ($urandom_range(0, 1) == 1);
         @(negedge clk);
         vectors++;
         if (w_rdy !== (!w_vld || snk_rdy)) begin
            errors++;
            $display("FAIL ready_rule cyc %0d: i_data_ready=%b required %b (valid=%b ready=%b)", cyc, w_rdy, !w_vld || snk_rdy, w_vld, snk_rdy);
         end
         if (prev_stall) begin
            vectors++;
            if (w_vld !== 1'b1 || w_win !== prev_win || w_end !== prev_end) begin
               errors++;
               $display("FAIL stall_hold cyc %0d: valid=%b win=%h end=%b required valid=1 win=%h end=%b", cyc, w_vld, w_win, w_end, prev_win, prev_end);
            end
         end
         prev_stall = w_vld && !snk_rdy;
         prev_win   = w_win;
         prev_end   = w_end;
         if (w_vld && snk_rdy) begin
            obs_win.push_back(w_win); obs_end.push_back(w_end);
            obs_x.push_back(int'(w_cx)); obs_y.push_back(int'(w_cy)); obs_cyc.push_back(cyc);
         end
         if (src_vld && w_rdy) begin
            acc_cyc.push_back(cyc);
            pi++;
         end
         if (pi >= npix) drain++;
         cyc++;
         if (cyc > npix*10 + 200) begin
            errors++;
            $display("FAIL drive_timeout: %0d of %0d pixels accepted after %0d cycles", pi, npix, cyc);
            break;
         end
      end
      @(posedge clk); #1;
      src_vld = 1'b0;
      snk_rdy = 1'b1;
   endtask

   task automatic check_windows(input string name, input int want_n);
      vectors++;
      if (obs_win.size() != want_n || exp_win.size() != want_n) begin
         errors++;
         $display("FAIL %s_count: got %0d windows, required %0d (model %0d)", name, obs_win.size(), want_n, exp_win.size());
      end
      for (int i = 0; i < obs_win.size() && i < exp_win.size(); i++) begin
         vectors++;
         if (obs_win[i] !== exp_win[i] || obs_end[i] !== exp_end[i]) begin
            errors++;
            $display("FAIL %s_win[%0d]: got %h end=%b, required %h end=%b", name, i, obs_win[i], obs_end[i], exp_win[i], exp_end[i]);
         end
`ifdef WINDOW_BUFFER_COORD_EN
         vectors++;
         if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
            errors++;
            $display("FAIL %s_coord[%0d]: got (%0d,%0d), required (%0d,%0d)", name, i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
         end
`endif
      end
   endtask

   task automatic test_reset();
      clear_n = 1'b0; src_vld = 1'b0; snk_rdy = 1'b0; src_dat = '0;
      repeat (3) @(posedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         vectors++;
         if (w_vld !== 1'b0 || w_end !== 1'b0 || w_rdy !== 1'b1 || w_cx !== 8'd0 || w_cy !== 8'd0) begin
            errors++;
            $display("FAIL reset_state dut%0d: valid=%b end=%b ready=%b coord=(%0d,%0d), required 0 0 1 (0,0)", s, w_vld, w_end, w_rdy, w_cx, w_cy);
         end
      end
      @(posedge clk); #1;
      clear_n = 1'b1;
      snk_rdy = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_basic();
      logic [215:0] got, first;
      int ends = 0;
      set_cfg(0, 8, 8, 1, 1);
      gen_frame(0, 0);
      build_exp(1);
      clear_obs();
      drive(64, 1'b0, 40);
      check_windows("basic", 36);
      first = {144'd0, 8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
      got = (obs_win.size() > 0) ? obs_win[0] : '1;
      vectors++;
      if (got !== first) begin
         errors++;
         $display("FAIL basic_first: got %h, required %h", got, first);
      end
      vectors++;
      if (obs_cyc.size() == 0 || acc_cyc.size() < 19 || obs_cyc[0] != acc_cyc[18] + 1) begin
         errors++;
         $display("FAIL basic_latency: first window cyc %0d, required %0d", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, (acc_cyc.size() > 18) ? acc_cyc[18] + 1 : -1);
      end
      foreach (obs_end[i]) if (obs_end[i]) ends++;
      got = (obs_win.size() > 0) ? obs_win[obs_win.size()-1] : '0;
      vectors++;
      if (ends != 1 || got[71:64] !== 8'd63 || obs_end.size() == 0 || obs_end[obs_end.size()-1] !== 1'b1) begin
         errors++;
         $display("FAIL basic_end: %0d end pulses, last newest pixel %0d, required 1 pulse on pixel 63", ends, got[71:64]);
      end
   endtask

   task automatic test_multich();
      logic [215:0] got;
      set_cfg(1, 10, 6, 3, 1);
      gen_frame(0, 0);
      build_exp(1);
      clear_obs();
      drive(60, 1'b0, 40);
      check_windows("multich", 32);
      got = (obs_win.size() > 0) ? obs_win[0] : '0;
      vectors++;
      if (got[23:16] !== 8'd128) begin
         errors++;
         $display("FAIL multich_ch2: got %0d, required 128", got[23:16]);
      end
   endtask

   task automatic test_stride();
      set_cfg(2, 7, 7, 1, 2);
      gen_frame(1, 0);
      build_exp(1);
      clear_obs();
      drive(49, 1'b0, 40);
      check_windows("stride", 9);
   endtask

   task automatic test_stall();
      set_cfg(0, 8, 8, 1, 1);
      gen_frame(1, 0);
      build_exp(1);
      clear_obs();
      drive(64, 1'b1, 40);
      check_windows("stall_a", 36);
      set_cfg(2, 7, 7, 1, 2);
      gen_frame(1, 0);
      build_exp(1);
      clear_obs();
      drive(49, 1'b1, 40);
      check_windows("stall_c", 9);
   endtask

   task automatic test_reset_mid();
      set_cfg(0, 8, 8, 1, 1);
      gen_frame(1, 0);
      clear_obs();
      drive(36, 1'b0, 0);
      clear_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (w_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_valid cycle %0d: valid=%b, required 0", i, w_vld);
         end
      end
      @(posedge clk); #1;
      clear_n = 1'b1;
      pixq.delete();
      gen_frame(1, 0);
      build_exp(1);
      clear_obs();
      drive(64, 1'b1, 40);
      check_windows("reset_mid", 36);
   endtask

   task automatic test_back_to_back();
      int ends = 0;
      logic [215:0] got;
      set_cfg(0, 8, 8, 1, 1);
      gen_frame(0, 0);
      gen_frame(0, 100);
      build_exp(2);
      clear_obs();
      drive(128, 1'b0, 40);
      check_windows("b2b", 72);
      foreach (obs_end[i]) if (obs_end[i]) ends++;
      vectors++;
      if (ends != 2) begin
         errors++;
         $display("FAIL b2b_ends: got %0d end pulses, required 2", ends);
      end
      got = (obs_win.size() > 36) ? obs_win[36] : '0;
      vectors++;
      if (got[31:0] !== {8'd108, 8'd102, 8'd101, 8'd100}) begin
         errors++;
         $display("FAIL b2b_frame2_first: got %h, required 6c666564", got[31:0]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      sel = 0;
      test_reset();
      test_basic();
      test_multich();
      test_stride();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
